// File: rtl/pwm_pkg.sv
// Shared types and widths for the PWM breathing sequencer and its pwm_ctrl pairing.
package pwm_pkg;

    localparam int PWM_WIDTH  = 16;
    localparam int PWM_HOLD_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RISE    = 3'd1,
        HOLD_HI = 3'd2,
        FALL    = 3'd3,
        HOLD_LO = 3'd4
    } pwm_state_e;

endpackage

// File: rtl/pwm_sat_step.sv
// Combinational saturating threshold step: rise clamps at max, fall clamps at zero.
module pwm_sat_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] thres,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] max,
    input  logic             dir,
    output logic [WIDTH-1:0] thres_next
);

    logic [WIDTH:0] sum;

    always_comb begin
        // one extra bit so a sum past full scale is seen as over max, not wrapped
        sum        = {1'b0, thres} + {1'b0, step};
        thres_next = '0;
        if (dir) begin
            thres_next = (sum >= {1'b0, max}) ? max : sum[WIDTH-1:0];
        end else begin
            thres_next = (thres > step) ? (thres - step) : '0;
        end
    end

endmodule

// File: rtl/pwm_breath_seq.sv
// Breathing duty sequencer for pwm_ctrl; threshold only moves on PWM period boundaries.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | outputs quiet, waiting for start_i
// RISE    | threshold stepping up towards max, one step per period
// HOLD_HI | threshold parked at max for hold periods
// FALL    | threshold stepping down towards 0, one step per period
// HOLD_LO | threshold parked at 0 for hold periods, then next breath
module pwm_breath_seq
    import pwm_pkg::*;
#(
    parameter int WIDTH  = PWM_WIDTH,
    parameter int HOLD_W = PWM_HOLD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              period_i,
    input  logic [WIDTH-1:0]  step_i,
    input  logic [WIDTH-1:0]  max_i,
    input  logic [HOLD_W-1:0] hold_i,
    input  logic [HOLD_W-1:0] cycles_i,
    output logic [WIDTH-1:0]  thres_o,
    output logic              enable_o,
    output logic              busy_o,
    output logic              done_o
);

    pwm_state_e        state_q, state_d;
    logic [WIDTH-1:0]  thres_q, thres_d;
    logic [WIDTH-1:0]  step_q, max_q;
    logic [HOLD_W-1:0] hold_q, cycles_q;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [HOLD_W-1:0] breath_q, breath_d, breath_inc;
    logic              stop_pend_q, stop_pend_d;
    logic              busy_q, done_q, done_d;
    logic              latch_cfg, stop_now;
    logic              do_rise, do_fall, to_idle;
    logic [WIDTH-1:0]  rise_val, fall_val;

    pwm_sat_step #(.WIDTH(WIDTH)) u_rise (
        .thres      (thres_q),
        .step       (step_q),
        .max        (max_q),
        .dir        (1'b1),
        .thres_next (rise_val)
    );

    pwm_sat_step #(.WIDTH(WIDTH)) u_fall (
        .thres      (thres_q),
        .step       (step_q),
        .max        (max_q),
        .dir        (1'b0),
        .thres_next (fall_val)
    );

    assign breath_inc = breath_q + 1'b1;
    assign stop_now   = stop_pend_q | stop_i;

    always_comb begin
        state_d     = state_q;
        thres_d     = thres_q;
        hold_cnt_d  = hold_cnt_q;
        breath_d    = breath_q;
        stop_pend_d = stop_pend_q;
        done_d      = 1'b0;
        latch_cfg   = 1'b0;
        do_rise     = 1'b0;
        do_fall     = 1'b0;
        to_idle     = 1'b0;

        if (state_q == IDLE) begin
            // a stop arriving with start is dropped: stop_pend is cleared here
            if (start_i) begin
                latch_cfg   = 1'b1;
                state_d     = RISE;
                thres_d     = '0;
                hold_cnt_d  = '0;
                breath_d    = '0;
                stop_pend_d = 1'b0;
            end
        end else begin
            if (stop_i) begin
                stop_pend_d = 1'b1;
            end
            if (period_i) begin
                unique case (state_q)
                    RISE: begin
                        if (stop_now) do_fall = 1'b1;
                        else          do_rise = 1'b1;
                    end
                    HOLD_HI: begin
                        if (stop_now || hold_cnt_q == hold_q) do_fall = 1'b1;
                        else hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                    FALL: do_fall = 1'b1;
                    HOLD_LO: begin
                        if (stop_now) begin
                            to_idle = 1'b1;
                        end else if (hold_cnt_q == hold_q) begin
                            breath_d = breath_inc;
                            if (cycles_q != '0 && breath_inc == cycles_q) to_idle = 1'b1;
                            else                                          do_rise = 1'b1;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                    default: to_idle = 1'b1;
                endcase
            end
        end

        // leaving a hold applies the first step of the next ramp in the same period
        if (do_rise) begin
            thres_d    = rise_val;
            hold_cnt_d = '0;
            state_d    = (rise_val == max_q) ? HOLD_HI : RISE;
        end

        if (do_fall) begin
            thres_d    = fall_val;
            hold_cnt_d = '0;
            if (fall_val != '0) state_d = FALL;
            else if (stop_now)  to_idle = 1'b1;
            else                state_d = HOLD_LO;
        end

        if (to_idle) begin
            state_d     = IDLE;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
            hold_cnt_d  = '0;
            breath_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            thres_q     <= '0;
            hold_cnt_q  <= '0;
            breath_q    <= '0;
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            thres_q     <= thres_d;
            hold_cnt_q  <= hold_cnt_d;
            breath_q    <= breath_d;
            stop_pend_q <= stop_pend_d;
            busy_q      <= (state_d != IDLE);
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_q   <= '0;
            max_q    <= '0;
            hold_q   <= '0;
            cycles_q <= '0;
        end else if (latch_cfg) begin
            // a zero step would never reach max, so it runs as a step of one
            step_q   <= (step_i == '0) ? WIDTH'(1) : step_i;
            max_q    <= max_i;
            hold_q   <= hold_i;
            cycles_q <= cycles_i;
        end
    end

    assign thres_o  = thres_q;
    assign enable_o = busy_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: doc/pwm_breath_seq.md
# pwm_breath_seq

Duty-cycle sequencer that drives the threshold and enable inputs of `pwm_ctrl` to produce a "breathing" waveform. It ramps the threshold from 0 to a programmed maximum and back, holding at each end, for a programmed number of breaths or indefinitely. All threshold changes occur only on PWM period boundaries, so `pwm_ctrl` never sees a mid-period duty glitch.

## Interface
- WIDTH, 16, threshold width; must match `pwm_ctrl`.
- HOLD_W, 8, width of the hold and breath-count fields.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle pulse; starts a sequence from IDLE.
- stop_i  in  1  one-cycle pulse; requests a graceful stop.
- period_i  in  1  one-cycle pulse, once per PWM period, coincident with the `pwm_ctrl` counter wrap 0xffff→0.
- step_i  in  WIDTH  threshold increment/decrement per period; latched at start.
- max_i  in  WIDTH  peak threshold; latched at start.
- hold_i  in  HOLD_W  periods to hold at the top and at the bottom; latched at start.
- cycles_i  in  HOLD_W  number of breaths; 0 means infinite; latched at start.
- thres_o  out  WIDTH  to `pwm_ctrl.thres_i`.
- enable_o  out  1  to `pwm_ctrl.enable_i`; high while busy.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse on return to IDLE.

## Operation
- States: IDLE, RISE, HOLD_HI, FALL, HOLD_LO.
- IDLE + start_i: latch the configuration and clear `thres` to 0. Clear the hold and breath counters. Go to RISE.
- A latched step of 0 is treated as 1.
- All transitions except the IDLE exit happen only in a cycle where period_i=1.
- RISE: `thres` ← min(thres+step, max), using a WIDTH+1-bit sum; no wrap-around.
  - If the new value equals max, go to HOLD_HI.
  - If max=0, go to HOLD_HI on the first period with thres=0.
- HOLD_HI: count periods. After hold periods have elapsed, go to FALL.
  - hold=0 means FALL on the next period.
- FALL: `thres` ← (thres>step) ? thres−step : 0. At 0, go to HOLD_LO.
- HOLD_LO: after hold periods have elapsed, increment the breath count.
  - If cycles≠0 and count==cycles: go to IDLE and pulse done_o.
  - Otherwise go to RISE.
- stop_i while busy sets `stop_pend`. With `stop_pend` set:
  - RISE and HOLD_HI go to FALL on the next period.
  - HOLD_LO goes to IDLE on the next period.
  - FALL continues to 0, then goes to IDLE, skipping HOLD_LO.
  - done_o pulses on entry to IDLE.
- start_i while busy is ignored.
- stop_i in IDLE is ignored.
- start_i and stop_i together in IDLE: start is accepted and stop is dropped.
- start_i and stop_i together while busy: the stop takes effect.

## Timing
- Reset values: thres_o=0, enable_o=0, busy_o=0, done_o=0, state=IDLE, all counters 0.
- Reset asserted mid-sequence returns everything to these values immediately. No done_o pulse is generated.
- All outputs are registered.
- start_i sampled at edge N: busy_o and enable_o are 1 and thres_o=0 from edge N+1.
- period_i sampled at edge N: the new thres_o is valid from edge N+1.
  - It is therefore stable before the next `pwm_ctrl` compare window.
- done_o is high for exactly the cycle after the final period_i. In that same cycle busy_o=0 and enable_o=0.
- A full breath takes ceil(max/step)×2 + 2×hold periods.

## Structure
- Shared package `pwm_pkg` holds:
  - the state enum (IDLE=0, RISE=1, HOLD_HI=2, FALL=3, HOLD_LO=4; 3-bit encoding);
  - the constants PWM_WIDTH=16 and PWM_HOLD_W=8.
- One sub-module is natural: `pwm_sat_step`, a combinational saturating add/subtract. It takes thres, step, max and dir, and returns the next threshold.
- The FSM, hold counter and breath counter stay in the top module.

## Test plan
- step=0x4000, max=0xC000, hold=2, cycles=1, one start:
  - thres_o per period: 0x4000, 0x8000, 0xC000;
  - 2 hold periods;
  - then 0x8000, 0x4000, 0x0000;
  - 2 hold periods;
  - then done_o for one cycle and busy_o=0.
- step=0x7000, max=0xFFFF: thres_o goes 0x7000, 0xE000, 0xFFFF (saturated, no wrap). The fall then reaches 0 via 0x8FFF, 0x1FFF, 0x0000.
- cycles=0, step=0x8000, max=0x8000, hold=0:
  - the breath repeats indefinitely (10+ breaths checked);
  - stop_i during HOLD_HI gives FALL to 0, then IDLE with done_o.
- step=0: behaves as step=1; thres_o increments by 1 per period.
- Ignored or overridden inputs:
  - start_i while busy: no change to the latched config or thres_o.
  - start_i with stop_i in IDLE: the sequence starts.
  - period_i held 0: thres_o stays frozen.
- rst asserted mid-RISE with thres_o=0x8000: all outputs go to 0 asynchronously. No done_o pulse. A new start then begins from thres 0.
